// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 2-flop sync, false-start reject, parity/framing/overrun flags, valid/ready out.
// Optional build macro UART_RX_CFG_MAJORITY_EN: 2-of-3 vote on every bit sample.
module uart_rx_cfg #(
    parameter int unsigned BASE_FREQ = 50_000_000,
    parameter int unsigned BAUDRATE  = 115_200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 1,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 overrun
);

    localparam int unsigned CPB   = BASE_FREQ / BAUDRATE;
    localparam int unsigned HALF  = (CPB - 1) / 2;
    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BRK
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [31:0]          r_ctr, w_ctr_nxt;
    logic [IDX_W-1:0]     r_idx, w_idx_nxt;
    logic                 r_stop_idx, w_stop_idx_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                 r_par_err, w_par_err_nxt;
    logic                 r_frm_err, w_frm_err_nxt;
    logic                 r_commit, w_commit_nxt;
    logic                 r_sync1, r_sync2;
    logic                 w_rxs;
    logic                 w_bit;
    logic                 w_accept;

    assign w_rxs    = r_sync2;
    assign w_accept = rx_valid && rx_ready;

    // Two-flop synchroniser; resets to the idle (high) line level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= serial_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef UART_RX_CFG_MAJORITY_EN
    logic [1:0] r_hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], w_rxs};
        end
    end

    // Vote over the two previous counts and the sample point itself
    assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rxs) | (r_hist[0] & w_rxs);
`else
    assign w_bit = w_rxs;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ctr      <= '0;
            r_idx      <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_commit   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ctr      <= w_ctr_nxt;
            r_idx      <= w_idx_nxt;
            r_stop_idx <= w_stop_idx_nxt;
            r_shift    <= w_shift_nxt;
            r_par_err  <= w_par_err_nxt;
            r_frm_err  <= w_frm_err_nxt;
            r_commit   <= w_commit_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ctr_nxt      = r_ctr;
        w_idx_nxt      = r_idx;
        w_stop_idx_nxt = r_stop_idx;
        w_shift_nxt    = r_shift;
        w_par_err_nxt  = r_par_err;
        w_frm_err_nxt  = r_frm_err;
        w_commit_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rxs) begin
                    w_state_nxt    = S_START;
                    w_ctr_nxt      = '0;
                    w_idx_nxt      = '0;
                    w_stop_idx_nxt = 1'b0;
                    w_par_err_nxt  = 1'b0;
                    w_frm_err_nxt  = 1'b0;
                end
            end
            S_START: begin
                if (r_ctr == HALF) begin
                    w_ctr_nxt   = '0;
                    w_state_nxt = w_bit ? S_IDLE : S_DATA;
                end else begin
                    w_ctr_nxt = r_ctr + 32'd1;
                end
            end
            S_DATA: begin
                if (r_ctr == CPB - 1) begin
                    w_ctr_nxt   = '0;
                    w_shift_nxt = {w_bit, r_shift[DATA_BITS-1:1]};
                    w_idx_nxt   = r_idx + IDX_W'(1);
                    if (r_idx == IDX_W'(DATA_BITS - 1)) begin
                        w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end else begin
                    w_ctr_nxt = r_ctr + 32'd1;
                end
            end
            S_PARITY: begin
                if (r_ctr == CPB - 1) begin
                    w_ctr_nxt     = '0;
                    w_par_err_nxt = ((^r_shift) ^ w_bit) != (PARITY == 2);
                    w_state_nxt   = S_STOP;
                end else begin
                    w_ctr_nxt = r_ctr + 32'd1;
                end
            end
            S_STOP: begin
                if (r_ctr == CPB - 1) begin
                    w_ctr_nxt      = '0;
                    w_stop_idx_nxt = r_stop_idx + 1'b1;
                    if (!w_bit) begin
                        w_frm_err_nxt = 1'b1;
                    end
                    if (r_stop_idx == 1'(STOP_BITS - 1)) begin
                        w_commit_nxt = 1'b1;
                        // A low final stop bit means a break: hold off until the line rises
                        w_state_nxt  = w_bit ? S_IDLE : S_BRK;
                    end
                end else begin
                    w_ctr_nxt = r_ctr + 32'd1;
                end
            end
            S_BRK: begin
                if (w_rxs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output word and handshake; a commit always wins over a plain accept
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            overrun      <= 1'b0;
        end else if (r_commit) begin
            rx_data      <= r_shift;
            parity_error <= r_par_err;
            frame_error  <= r_frm_err;
            rx_valid     <= 1'b1;
            overrun      <= rx_valid && !rx_ready;
        end else if (w_accept) begin
            rx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations (8E1, 8O1, 5N2) at CPB=10, directed and random frames.
module tb_uart_rx_cfg;

    localparam int unsigned CPB = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] sin;
    logic [2:0] rdy;
    wire  [7:0] data0, data1;
    wire  [4:0] data2;
    wire  [2:0] valid, perr, ferr, ovr;

    int n_cmp = 0;
    int n_bad = 0;
    logic [2:0] pend;

    uart_rx_cfg #(.BASE_FREQ(1_000_000), .BAUDRATE(100_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .serial_in(sin[0]), .rx_data(data0), .rx_valid(valid[0]),
        .rx_ready(rdy[0]), .parity_error(perr[0]), .frame_error(ferr[0]), .overrun(ovr[0]));

    uart_rx_cfg #(.BASE_FREQ(1_000_000), .BAUDRATE(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .serial_in(sin[1]), .rx_data(data1), .rx_valid(valid[1]),
        .rx_ready(rdy[1]), .parity_error(perr[1]), .frame_error(ferr[1]), .overrun(ovr[1]));

    uart_rx_cfg #(.BASE_FREQ(1_000_000), .BAUDRATE(100_000), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u_5n2 (
        .clk(clk), .rst(rst), .serial_in(sin[2]), .rx_data(data2), .rx_valid(valid[2]),
        .rx_ready(rdy[2]), .parity_error(perr[2]), .frame_error(ferr[2]), .overrun(ovr[2]));

    function automatic int nbits(input int d);
        return (d == 2) ? 5 : 8;
    endfunction

    function automatic int pmode(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 2 : 0);
    endfunction

    function automatic int nstop(input int d);
        return (d == 2) ? 2 : 1;
    endfunction

    function automatic logic [31:0] rd_data(input int d);
        case (d)
            0:       return 32'(data0);
            1:       return 32'(data1);
            default: return 32'(data2);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Serialise one frame LSB first; optional one-cycle glitch mid-bit and extra low hold after it
    task automatic send(input int d, input logic [8:0] dat, input logic pflip, input logic [1:0] stops,
                        input int glitch, input int extra_low);
        logic [15:0] fb;
        int          len;
        logic        v;
        fb  = '0;
        len = 0;
        fb[len] = 1'b0;
        len++;
        for (int i = 0; i < nbits(d); i++) begin
            fb[len] = dat[i];
            len++;
        end
        if (pmode(d) != 0) begin
            fb[len] = (^dat) ^ (pmode(d) == 2) ^ pflip;
            len++;
        end
        for (int i = 0; i < nstop(d); i++) begin
            fb[len] = stops[i];
            len++;
        end
        @(posedge clk); #1;
        for (int b = 0; b < len; b++) begin
            for (int c = 0; c < int'(CPB); c++) begin
                v = fb[b];
                if (b == glitch && c == int'(CPB / 2)) v = ~v;
                sin[d] = v;
                @(posedge clk); #1;
            end
        end
        for (int c = 0; c < extra_low; c++) begin
            sin[d] = 1'b0;
            @(posedge clk); #1;
        end
        sin[d] = 1'b1;
    endtask

    task automatic accept(input int d);
        @(negedge clk);
        rdy[d] = 1'b1;
        @(negedge clk);
        rdy[d] = 1'b0;
        chk($sformatf("d%0d valid_after_accept", d), 32'(valid[d]), 32'd0);
        pend[d] = 1'b0;
    endtask

    // Send a frame, then compare against the expected word and flags derived from what was sent
    task automatic frame(input int d, input logic [8:0] dat, input logic pflip, input logic [1:0] stops,
                         input int glitch, input int extra_low, input logic acc);
        logic epe, efe;
        epe = (pmode(d) != 0) && pflip;
        efe = (nstop(d) == 2) ? !(stops[0] && stops[1]) : !stops[0];
        send(d, dat, pflip, stops, glitch, extra_low);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk($sformatf("d%0d valid", d), 32'(valid[d]), 32'd1);
        chk($sformatf("d%0d data", d), rd_data(d), 32'(dat));
        chk($sformatf("d%0d parity_error", d), 32'(perr[d]), 32'(epe));
        chk($sformatf("d%0d frame_error", d), 32'(ferr[d]), 32'(efe));
        chk($sformatf("d%0d overrun", d), 32'(ovr[d]), 32'(pend[d]));
        pend[d] = 1'b1;
        if (acc) accept(d);
        repeat (CPB) @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         d;
        logic [8:0] dat;
        logic       pflip, acc, last;
        logic [1:0] stops;
        int         extra;

        rst  = 1'b1;
        sin  = 3'b111;
        rdy  = 3'b000;
        pend = 3'b000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset valid", 32'(valid), 32'd0);
        chk("reset data0", 32'(data0), 32'd0);
        chk("reset data2", 32'(data2), 32'd0);
        chk("reset flags", 32'(perr | ferr | ovr), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (CPB) @(posedge clk);

        frame(0, 9'h0A5, 1'b0, 2'b11, -1, 0, 1'b1);
        frame(0, 9'h007, 1'b1, 2'b11, -1, 0, 1'b1);
        frame(1, 9'h007, 1'b0, 2'b11, -1, 0, 1'b1);

        // Break: stop bit low and line held low, then no second frame may appear
        frame(0, 9'h03C, 1'b0, 2'b10, -1, 30, 1'b1);
        repeat (15 * CPB) @(posedge clk);
        @(negedge clk);
        chk("break no_retrigger", 32'(valid[0]), 32'd0);

        frame(0, 9'h011, 1'b0, 2'b11, -1, 0, 1'b0);
        frame(0, 9'h022, 1'b0, 2'b11, -1, 0, 1'b1);

        // False start: 3-cycle low pulse on an idle line
        @(posedge clk); #1;
        sin[0] = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        sin[0] = 1'b1;
        repeat (15 * CPB) @(posedge clk);
        @(negedge clk);
        chk("false_start valid", 32'(valid[0]), 32'd0);

`ifdef UART_RX_CFG_MAJORITY_EN
        frame(0, 9'h000, 1'b0, 2'b11, 4, 0, 1'b1);
`endif

        frame(2, 9'h01B, 1'b0, 2'b11, -1, 0, 1'b0);

        // Reset in the middle of a frame while a word is still pending
        @(posedge clk); #1;
        sin[2] = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
        end
        rst    = 1'b1;
        sin[2] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst valid", 32'(valid), 32'd0);
        chk("midrst data2", 32'(data2), 32'd0);
        chk("midrst flags", 32'(perr | ferr | ovr), 32'd0);
        pend = 3'b000;
        repeat (CPB) @(posedge clk);
        frame(2, 9'h00A, 1'b0, 2'b11, -1, 0, 1'b1);

        for (int it = 0; it < 36; it++) begin
            d     = int'($urandom_range(0, 2));
            dat   = 9'($urandom_range(0, (1 << nbits(d)) - 1));
            pflip = ($urandom_range(0, 3) == 0);
            stops = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            last  = (nstop(d) == 2) ? stops[1] : stops[0];
            extra = last ? 0 : int'($urandom_range(0, 30));
            acc   = 1'($urandom_range(0, 1));
            frame(d, dat, pflip, stops, -1, extra, acc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
